pattern_det_arbiter: RTL and testbench

Shares one programmable serial pattern detector among `N_CH` independent bit streams. Each cycle it grants one requesting channel in round-robin order and consumes that channel's bit. The bit is evaluated against a per-channel saved history, so every channel gets overlapping detection of `PATTERN` (default 1001). The block keeps per-channel saturating match counters. It sits between the serial front-ends and the status/interrupt logic.

---
 rtl/pattern_det_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/pattern_det_arbiter.sv | 111 +++++++++++
 tb/tb_pattern_det_arbiter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/pattern_det_pkg.sv
// Shared defaults and index-width helper for the multi-channel pattern detector.
package pattern_det_pkg;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int         DEF_N_CH    = 4;
  localparam int         DEF_PAT_W   = 4;
  localparam logic [3:0] DEF_PATTERN = 4'b1001;
  localparam int         DEF_CNT_W   = 8;
  localparam int         CH_W        = idx_w(DEF_N_CH);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or after ptr.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt
);

  localparam int PW = $clog2(N);

  logic          w_found;
  logic [PW-1:0] w_idx;

  always_comb begin
    gnt     = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < N; i++) begin
      w_idx = PW'((int'(ptr) + i) % N);
      for (int k = 0; k < N; k++) begin
        if (!w_found && req[k] && (w_idx == PW'(k))) begin
          gnt[k]  = 1'b1;
          w_found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pattern_det_arbiter.sv
// One shared serial pattern comparator time-multiplexed over N_CH streams, with
// per-channel history, fill level and saturating match counters.
module pattern_det_arbiter
  import pattern_det_pkg::*;
#(
  parameter int               N_CH    = DEF_N_CH,
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
  parameter int               CNT_W   = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CH-1:0]           req,
  input  logic [N_CH-1:0]           din,
  input  logic [N_CH-1:0]           flush,
  input  logic [N_CH-1:0]           clr_cnt,
  output logic [N_CH-1:0]           gnt,
  output logic                      match_vld,
  output logic [idx_w(N_CH)-1:0]    match_ch,
  output logic [N_CH*CNT_W-1:0]     match_cnt
);

  localparam int               IDX_W    = idx_w(N_CH);
  localparam int               HW       = PAT_W - 1;
  localparam int               FW       = $clog2(PAT_W);
  localparam logic [FW-1:0]    FILL_MAX = FW'(PAT_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_match_ch;
  logic             r_match_vld;
  logic [HW-1:0]    r_hist [N_CH];
  logic [FW-1:0]    r_fill [N_CH];
  logic [CNT_W-1:0] r_cnt  [N_CH];

  logic [N_CH-1:0]  w_eff_req;
  logic             w_take;
  logic             w_bit;
  logic             w_hit;
  logic [IDX_W-1:0] w_ch;
  logic [HW-1:0]    w_hist_sel;
  logic [HW-1:0]    w_hist_nxt;
  logic [FW-1:0]    w_fill_sel;

  // A channel being flushed this cycle must not be granted; its bit stays pending.
  assign w_eff_req = req & ~flush;

  rr_arbiter #(.N(N_CH)) u_arb (
    .req (w_eff_req),
    .ptr (r_ptr),
    .gnt (gnt)
  );

  // Stage p0: select the granted channel's state and run the shared compare
  always_comb begin
    w_ch       = '0;
    w_bit      = 1'b0;
    w_hist_sel = '0;
    w_fill_sel = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (gnt[k]) begin
        w_ch       = IDX_W'(k);
        w_bit      = din[k];
        w_hist_sel = r_hist[k];
        w_fill_sel = r_fill[k];
      end
    end
  end

  assign w_take     = |gnt;
  // Truncating {hist,b} keeps the newest PAT_W-1 bits, which also covers PAT_W==2.
  assign w_hist_nxt = HW'({w_hist_sel, w_bit});
  assign w_hit      = w_take && (w_fill_sel == FILL_MAX) && ({w_hist_sel, w_bit} == PATTERN);

  // Stage p1: commit per-channel state, pointer and match report
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= '0;
      r_match_vld <= 1'b0;
      r_match_ch  <= '0;
      for (int k = 0; k < N_CH; k++) begin
        r_hist[k] <= '0;
        r_fill[k] <= '0;
        r_cnt[k]  <= '0;
      end
    end else begin
      r_match_vld <= w_hit;
      if (w_hit) r_match_ch <= w_ch;
      if (w_take) r_ptr <= (w_ch == IDX_W'(N_CH - 1)) ? '0 : w_ch + 1'b1;
      for (int k = 0; k < N_CH; k++) begin
        if (flush[k]) begin
          r_hist[k] <= '0;
          r_fill[k] <= '0;
        end else if (gnt[k]) begin
          r_hist[k] <= w_hist_nxt;
          if (r_fill[k] != FILL_MAX) r_fill[k] <= r_fill[k] + 1'b1;
        end
        if (clr_cnt[k]) r_cnt[k] <= '0;
        else if (w_hit && gnt[k] && (r_cnt[k] != CNT_MAX)) r_cnt[k] <= r_cnt[k] + 1'b1;
      end
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_cnt
    assign match_cnt[k*CNT_W +: CNT_W] = r_cnt[k];
  end

  assign match_vld = r_match_vld;
  assign match_ch  = r_match_ch;

endmodule

// File: tb/tb_pattern_det_arbiter.sv
// Directed bench for pattern_det_arbiter: vector table plus saturation/clear sequences.
module tb_pattern_det_arbiter;
  import pattern_det_pkg::*;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [3:0]      req = '0;
  logic [3:0]      din = '0;
  logic [3:0]      flush = '0;
  logic [3:0]      clr_cnt = '0;
  logic [3:0]      gnt;
  logic            match_vld;
  logic [CH_W-1:0] match_ch;
  logic [31:0]     match_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  din;
    logic [3:0]  flush;
    logic [3:0]  clr;
    logic [3:0]  gnt;
    logic        vld;
    logic [1:0]  ch;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[$];

  pattern_det_arbiter u_dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .din       (din),
    .flush     (flush),
    .clr_cnt   (clr_cnt),
    .gnt       (gnt),
    .match_vld (match_vld),
    .match_ch  (match_ch),
    .match_cnt (match_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] d,
                     input logic [3:0] f, input logic [3:0] c, input logic [3:0] g,
                     input logic v, input logic [1:0] ch, input logic [31:0] cn);
    vec_t e;
    e.rst = r; e.req = rq; e.din = d; e.flush = f; e.clr = c;
    e.gnt = g; e.vld = v; e.ch = ch; e.cnt = cn;
    tbl.push_back(e);
  endtask

  task automatic put(input logic [3:0] rq, input logic [3:0] d, input logic [3:0] c);
    @(negedge clk);
    req = rq; din = d; flush = '0; clr_cnt = c;
    #1;
  endtask

  initial begin
    int pulses;
    logic [3:0] d;

    // Round robin with all four requesting; ch0 and ch3 each carry 1001 in their own slots
    add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 32'h0);
    for (int c = 0; c < 16; c++) begin
      d = ((c / 4) == 0 || (c / 4) == 3) ? 4'b1011 : 4'b0010;
      add(0, 4'b1111, d, 4'b0000, 4'b0000, 4'(1 << (c % 4)),
          (c == 13), 2'd0, (c >= 13) ? 32'h0000_0001 : 32'h0);
    end
    add(0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1, 3, 32'h0100_0001);
    // Fresh start, channel 0: 1,0,0,1
    add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 32'h0);
    add(0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 0, 0, 32'h0);
    add(0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 0, 0, 32'h0);
    add(0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 0, 0, 32'h0);
    add(0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 0, 0, 32'h0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 0, 32'h0000_0001);
    // Channel 1: 1,0,0,1,0,0,1 -> two overlapping hits
    add(0, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 0, 0, 32'h0000_0001);
    add(0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 0, 0, 32'h0000_0001);
    add(0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 0, 0, 32'h0000_0001);
    add(0, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 0, 0, 32'h0000_0001);
    add(0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 1, 1, 32'h0000_0101);
    add(0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 0, 0, 32'h0000_0101);
    add(0, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 0, 0, 32'h0000_0101);
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 1, 32'h0000_0201);
    // Channel 2: 1,0,0, flush (blocks grant), then 1 -> no match
    add(0, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 0, 0, 32'h0000_0201);
    add(0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 0, 0, 32'h0000_0201);
    add(0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 0, 0, 32'h0000_0201);
    add(0, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 0, 0, 32'h0000_0201);
    add(0, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 0, 0, 32'h0000_0201);
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 32'h0000_0201);
    // Channel 3: 1,0,0, async reset, then a lone 1 -> no match
    add(0, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 0, 0, 32'h0000_0201);
    add(0, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 0, 0, 32'h0000_0201);
    add(0, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 0, 0, 32'h0000_0201);
    add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 32'h0);
    add(0, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 0, 0, 32'h0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 32'h0);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].rst; req = tbl[i].req; din = tbl[i].din;
      flush = tbl[i].flush; clr_cnt = tbl[i].clr;
      #1;
      chk($sformatf("row%0d gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("row%0d match_vld", i), 32'(match_vld), 32'(tbl[i].vld));
      if (tbl[i].vld || tbl[i].rst)
        chk($sformatf("row%0d match_ch", i), 32'(match_ch), 32'(tbl[i].ch));
      chk($sformatf("row%0d match_cnt", i), match_cnt, tbl[i].cnt);
      if (tbl[i].rst) begin
        #1 rst = 1'b0;
      end
    end

    // Channel 3 holds one bit (1); each 0,0,1 from here completes 1001 by overlap
    pulses = 0;
    for (int n = 0; n < 255; n++) begin
      put(4'b1000, 4'b0000, 4'b0000);
      if (match_vld) pulses++;
      put(4'b1000, 4'b0000, 4'b0000);
      if (match_vld) pulses++;
      put(4'b1000, 4'b1000, 4'b0000);
      if (match_vld) pulses++;
    end
    put(4'b0000, 4'b0000, 4'b0000);
    if (match_vld) pulses++;
    chk("sat pulses", 32'(pulses), 32'd255);
    chk("sat cnt255", match_cnt, 32'hFF00_0000);

    put(4'b1000, 4'b0000, 4'b0000);
    put(4'b1000, 4'b0000, 4'b0000);
    put(4'b1000, 4'b1000, 4'b0000);
    put(4'b0000, 4'b0000, 4'b0000);
    chk("sat extra vld", 32'(match_vld), 32'd1);
    chk("sat extra ch", 32'(match_ch), 32'd3);
    chk("sat hold cnt", match_cnt, 32'hFF00_0000);

    put(4'b1000, 4'b0000, 4'b0000);
    put(4'b1000, 4'b0000, 4'b0000);
    put(4'b1000, 4'b1000, 4'b1000);
    put(4'b0000, 4'b0000, 4'b0000);
    chk("clr+hit vld", 32'(match_vld), 32'd1);
    chk("clr+hit cnt", match_cnt, 32'h0000_0000);

    put(4'b1000, 4'b0000, 4'b0000);
    put(4'b1000, 4'b0000, 4'b0000);
    put(4'b1000, 4'b1000, 4'b0000);
    put(4'b0000, 4'b0000, 4'b0000);
    chk("after clr vld", 32'(match_vld), 32'd1);
    chk("after clr cnt", match_cnt, 32'h0100_0000);
    put(4'b0000, 4'b0000, 4'b0000);
    chk("idle vld", 32'(match_vld), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
